// File: rtl/stream_call_arbiter_pkg.sv
// Shared types and defaults for the stream call arbiter.
// INT_W follows the project-wide `intN width; 32 bits when that is not defined.
`ifndef intN
`define intN 32
`endif

package stream_call_arbiter_pkg;
  localparam int INT_W_DEF = `intN;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/stream_call_arbiter_if.sv
// Requester, callee and response signals of the stream call arbiter.
// The master side drives requests and the callee stream; the slave side is the arbiter.
interface stream_call_arbiter_if
  import stream_call_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int INT_W = INT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [N-1:0]       req_valid;
  logic [N*INT_W-1:0] req_arg;
  logic [N*CNT_W-1:0] req_count;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [INT_W-1:0]   rsp_data;
  logic               rsp_last;
  logic               call_valid;
  logic               call_ready;
  logic [INT_W-1:0]   call_arg;
  logic               strm_valid;
  logic               strm_ready;
  logic [INT_W-1:0]   strm_data;

  modport master (
    output req_valid, req_arg, req_count, rsp_ready, call_ready, strm_valid, strm_data,
    input  req_ready, rsp_valid, rsp_data, rsp_last, call_valid, call_arg, strm_ready
  );

  modport slave (
    input  req_valid, req_arg, req_count, rsp_ready, call_ready, strm_valid, strm_data,
    output req_ready, rsp_valid, rsp_data, rsp_last, call_valid, call_arg, strm_ready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning cyclically from ptr.
// Zero latency, no state; any=0 when nothing is requested.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);
  localparam int W = $clog2(N);

  always_comb begin : p_pick
    int idx;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = W'(idx);
      end
    end
  end
endmodule

// File: rtl/stream_call_arbiter.sv
// Shares one streaming callee among N requesters round-robin: accept, call, forward count elements.
// Accept is combinational in IDLE; elements pass through with zero latency under the winner's rsp_ready.
module stream_call_arbiter
  import stream_call_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int INT_W = INT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  stream_call_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, r_gnt;
  logic [CNT_W-1:0] r_rem;
  logic [INT_W-1:0] r_arg;

  logic [N-1:0]     w_gnt_oh;
  logic [PW-1:0]    w_gnt_idx;
  logic             w_any;
  logic [CNT_W-1:0] w_cnt_sel;
  logic [INT_W-1:0] w_arg_sel;
  logic             w_xfer;

  rr_arbiter #(.N(N)) u_rr (
    .req          (bus.req_valid),
    .ptr          (r_ptr),
    .grant_onehot (w_gnt_oh),
    .grant_idx    (w_gnt_idx),
    .any          (w_any)
  );

  assign w_cnt_sel = bus.req_count[int'(w_gnt_idx)*CNT_W +: CNT_W];
  assign w_arg_sel = bus.req_arg[int'(w_gnt_idx)*INT_W +: INT_W];
  assign w_xfer    = (r_state == ST_STREAM) && bus.strm_valid && bus.rsp_ready[r_gnt];

  always_comb begin
    w_state_nxt    = r_state;
    bus.req_ready  = '0;
    bus.call_valid = 1'b0;
    bus.call_arg   = r_arg;
    bus.rsp_valid  = '0;
    bus.rsp_last   = 1'b0;
    bus.strm_ready = 1'b0;
    bus.rsp_data   = bus.strm_data;
    case (r_state)
      ST_IDLE: begin
        // Acceptance is suppressed while reset is held so every output reads 0.
        if (w_any && !rst) begin
          bus.req_ready = w_gnt_oh;
          if (w_cnt_sel != '0) w_state_nxt = ST_CALL;
        end
      end
      ST_CALL: begin
        bus.call_valid = 1'b1;
        if (bus.call_ready) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        bus.strm_ready       = bus.rsp_ready[r_gnt];
        bus.rsp_valid[r_gnt] = bus.strm_valid;
        bus.rsp_last         = (r_rem == CNT_W'(1));
        if (w_xfer && r_rem == CNT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_rem   <= '0;
      r_arg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any) begin
        r_gnt <= w_gnt_idx;
        r_arg <= w_arg_sel;
        r_rem <= w_cnt_sel;
        // A zero-count grant is consumed on the spot and rotates priority.
        if (w_cnt_sel == '0) r_ptr <= PW'(next_idx(int'(w_gnt_idx), N));
      end
      if (w_xfer) begin
        r_rem <= r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) r_ptr <= PW'(next_idx(int'(r_gnt), N));
      end
    end
  end
endmodule

// File: tb/tb_stream_call_arbiter.sv
// Table vectors, directed corner sequences and random traffic checked against a transaction-level model.
module tb_stream_call_arbiter;
  import stream_call_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int INT_W = INT_W_DEF;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_call_arbiter_if #(.N(N), .INT_W(INT_W), .CNT_W(CNT_W)) bus ();
  stream_call_arbiter #(.N(N), .INT_W(INT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0]     rv;
  logic [INT_W-1:0] ra [N];
  logic [CNT_W-1:0] rc [N];
  logic [N-1:0]     rrdy;
  logic             crdy;
  logic             sen;

  always_comb begin
    bus.req_valid  = rv;
    bus.rsp_ready  = rrdy;
    bus.call_ready = crdy;
    for (int i = 0; i < N; i++) begin
      bus.req_arg[i*INT_W +: INT_W]   = ra[i];
      bus.req_count[i*CNT_W +: CNT_W] = rc[i];
    end
  end

  // Callee: restarts at the argument on every call handshake, then counts up per transfer.
  logic [INT_W-1:0] cal_cur;
  logic             cal_on;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cal_on  <= 1'b0;
      cal_cur <= '0;
    end else if (bus.call_valid && bus.call_ready) begin
      cal_cur <= bus.call_arg;
      cal_on  <= 1'b1;
    end else if (bus.strm_valid && bus.strm_ready) begin
      cal_cur <= cal_cur + 1'b1;
    end
  end
  assign bus.strm_valid = cal_on & sen;
  assign bus.strm_data  = cal_cur;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Transaction-level model: phase 0 arbitrate, 1 call outstanding, 2 streaming the queued elements.
  int               m_phase, m_ptr, m_g;
  logic [INT_W-1:0] m_arg;
  logic [INT_W-1:0] m_q[$];
  int               glog[$];
  logic [INT_W-1:0] obs_d[$];
  logic             obs_l[$];
  int               xfer_cnt[N];
  logic [N-1:0]     drop;

  task automatic cycle();
    logic [N-1:0] e_rr, e_rv;
    logic e_cv, e_last, e_sr;
    int win;
    @(negedge clk);
    #1;
    e_rr = '0; e_rv = '0; e_cv = 1'b0; e_last = 1'b0; e_sr = 1'b0; win = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++)
        if (win < 0 && rv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) e_rr[win] = 1'b1;
    end else if (m_phase == 1) begin
      e_cv = 1'b1;
    end else begin
      e_sr       = rrdy[m_g];
      e_rv[m_g]  = bus.strm_valid;
      e_last     = (m_q.size() == 1);
    end
    chk("ctrl", 64'({bus.req_ready, bus.call_valid, bus.rsp_valid, bus.rsp_last, bus.strm_ready}),
        64'({e_rr, e_cv, e_rv, e_last, e_sr}));
    if (e_cv) chk("call_arg", 64'(bus.call_arg), 64'(m_arg));
    if (e_rv != '0) chk("rsp_data", 64'(bus.rsp_data), 64'(m_q[0]));
    if ((bus.rsp_valid & rrdy) != '0) begin
      obs_d.push_back(bus.rsp_data);
      obs_l.push_back(bus.rsp_last);
      for (int i = 0; i < N; i++) if (bus.rsp_valid[i] & rrdy[i]) xfer_cnt[i]++;
    end
    if (m_phase == 0 && win >= 0) begin
      glog.push_back(win);
      drop[win] = 1'b1;
      if (rc[win] == '0) m_ptr = (win + 1) % N;
      else begin
        m_phase = 1;
        m_g     = win;
        m_arg   = ra[win];
        for (int k = 0; k < int'(rc[win]); k++) m_q.push_back(ra[win] + INT_W'(k));
      end
    end else if (m_phase == 1 && crdy) begin
      m_phase = 2;
    end else if (m_phase == 2 && bus.strm_valid && rrdy[m_g]) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_phase = 0;
        m_ptr   = (m_g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    rv   = rv & ~drop;
    drop = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out", 64'({bus.req_ready, bus.call_valid, bus.rsp_valid, bus.rsp_last, bus.strm_ready}), 64'd0);
    rv = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_phase = 0; m_ptr = 0; m_g = 0;
    m_q.delete();
    drop = '0;
  endtask

  // Runs until a new grant has been taken and the model is idle again.
  task automatic run_grant(input string name);
    int g0, n;
    g0 = glog.size();
    n  = 0;
    while ((glog.size() == g0 || m_phase != 0) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) chk({name, "_timeout"}, 64'(n), 64'd0);
  endtask

  typedef struct {
    logic [N-1:0]     rv;
    logic [N-1:0]     rr;
    logic             cv;
    logic [INT_W-1:0] ca;
    logic [N-1:0]     rsv;
    logic             last;
    logic             sr;
    logic [INT_W-1:0] d;
  } vec_t;
  vec_t tv[12];

  int exp_ord[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int n;
    logic raised;
    rv = '0; rrdy = '1; crdy = 1'b1; sen = 1'b1; drop = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rc[i] = '0; xfer_cnt[i] = 0; end
    m_phase = 0; m_ptr = 0; m_g = 0; m_arg = '0;
    do_reset();

    // Single request (42 x3) followed by a zero-count request on req1 that yields to req2.
    ra[0] = 42; rc[0] = 3; ra[1] = 5; rc[1] = 0; ra[2] = 100; rc[2] = 2;
    tv[0]  = '{4'b0001, 4'b0001, 1'b0, 32'd0,   4'b0000, 1'b0, 1'b0, 32'd0};
    tv[1]  = '{4'b0000, 4'b0000, 1'b1, 32'd42,  4'b0000, 1'b0, 1'b0, 32'd0};
    tv[2]  = '{4'b0000, 4'b0000, 1'b0, 32'd0,   4'b0001, 1'b0, 1'b1, 32'd42};
    tv[3]  = '{4'b0000, 4'b0000, 1'b0, 32'd0,   4'b0001, 1'b0, 1'b1, 32'd43};
    tv[4]  = '{4'b0000, 4'b0000, 1'b0, 32'd0,   4'b0001, 1'b1, 1'b1, 32'd44};
    tv[5]  = '{4'b0000, 4'b0000, 1'b0, 32'd0,   4'b0000, 1'b0, 1'b0, 32'd0};
    tv[6]  = '{4'b0110, 4'b0010, 1'b0, 32'd0,   4'b0000, 1'b0, 1'b0, 32'd0};
    tv[7]  = '{4'b0100, 4'b0100, 1'b0, 32'd0,   4'b0000, 1'b0, 1'b0, 32'd0};
    tv[8]  = '{4'b0000, 4'b0000, 1'b1, 32'd100, 4'b0000, 1'b0, 1'b0, 32'd0};
    tv[9]  = '{4'b0000, 4'b0000, 1'b0, 32'd0,   4'b0100, 1'b0, 1'b1, 32'd100};
    tv[10] = '{4'b0000, 4'b0000, 1'b0, 32'd0,   4'b0100, 1'b1, 1'b1, 32'd101};
    tv[11] = '{4'b0000, 4'b0000, 1'b0, 32'd0,   4'b0000, 1'b0, 1'b0, 32'd0};
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      rv = tv[r].rv;
      #1;
      chk("vec_ctrl", 64'({bus.req_ready, bus.call_valid, bus.rsp_valid, bus.rsp_last, bus.strm_ready}),
          64'({tv[r].rr, tv[r].cv, tv[r].rsv, tv[r].last, tv[r].sr}));
      if (tv[r].cv) chk("vec_call_arg", 64'(bus.call_arg), 64'(tv[r].ca));
      if (tv[r].rsv != '0) chk("vec_rsp_data", 64'(bus.rsp_data), 64'(tv[r].d));
    end

    // All four request from reset; req0 and req1 come back while req3 is served.
    do_reset();
    glog.delete();
    for (int i = 0; i < N; i++) begin ra[i] = INT_W'(10 * (i + 1)); rc[i] = 2; end
    rv = '1; n = 0; raised = 1'b0;
    while (!(glog.size() >= 6 && m_phase == 0) && n < 200) begin
      cycle();
      n++;
      if (glog.size() == 4 && !raised) begin rv[0] = 1'b1; rv[1] = 1'b1; raised = 1'b1; end
    end
    chk("rr_count", 64'(glog.size()), 64'd6);
    for (int k = 0; k < 6 && k < glog.size(); k++) chk("rr_order", 64'(glog[k]), 64'(exp_ord[k]));

    // Backpressure on req2 with rsp_ready pattern 1,0,0,1.
    do_reset();
    obs_d.delete(); obs_l.delete();
    for (int i = 0; i < N; i++) xfer_cnt[i] = 0;
    ra[2] = 200; rc[2] = 4; rv = 4'b0100;
    n = 0;
    begin
      int g0;
      g0 = glog.size();
      while ((glog.size() == g0 || m_phase != 0) && n < 100) begin
        rrdy    = '1;
        rrdy[2] = (n % 4 == 0) || (n % 4 == 3);
        cycle();
        n++;
      end
    end
    rrdy = '1;
    chk("bp_xfers", 64'(xfer_cnt[2]), 64'd4);
    chk("bp_len", 64'(obs_d.size()), 64'd4);
    for (int k = 0; k < obs_d.size() && k < 4; k++) chk("bp_data", 64'(obs_d[k]), 64'(200 + k));

    // Reset after 2 of 5 elements, then a fresh single-element call.
    do_reset();
    ra[0] = 50; rc[0] = 5; rv = 4'b0001; n = 0;
    while (!(m_phase == 2 && m_q.size() == 3) && n < 50) begin cycle(); n++; end
    chk("mid_progress", 64'(m_q.size()), 64'd3);
    rv = '1;
    do_reset();
    obs_d.delete(); obs_l.delete();
    ra[0] = 7; rc[0] = 1; rv = 4'b0001;
    run_grant("post_rst");
    chk("post_rst_len", 64'(obs_d.size()), 64'd1);
    if (obs_d.size() > 0) begin
      chk("post_rst_data", 64'(obs_d[0]), 64'd7);
      chk("post_rst_last", 64'(obs_l[0]), 64'd1);
    end

    // Callee stalls the call for 5 cycles.
    do_reset();
    crdy = 1'b0; ra[0] = 99; rc[0] = 2; rv = 4'b0001;
    cycle();
    repeat (5) cycle();
    chk("call_hold", 64'({bus.call_valid, bus.rsp_valid, bus.call_arg}), 64'({1'b1, 4'b0000, 32'd99}));
    crdy = 1'b1;
    n = 0;
    while (m_phase != 0 && n < 50) begin cycle(); n++; end
    chk("call_hold_done", 64'(m_phase), 64'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = INT_W'($urandom);
          rc[i] = CNT_W'($urandom_range(0, 5));
        end
      end
      rrdy = N'($urandom);
      crdy = ($urandom_range(0, 3) != 0);
      sen  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rv = '0; rrdy = '1; crdy = 1'b1; sen = 1'b1;
    n = 0;
    while (m_phase != 0 && n < 300) begin cycle(); n++; end
    chk("rand_drain", 64'(m_phase), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
